cone_vector_sequencer: RTL

- Exhaustive-vector test sequencer for one small synthesized combinational logic cone (N_IN inputs, one output), such as an extracted AES netlist slice.
- Drives every input vector onto the cone in ascending order, waits a programmable settle time, then samples the cone output.
- Compares each sample against an expected truth table latched at start, and reports pass/fail, the mismatch count, the first failing vector and the captured truth table.
- Sits between the netlist-validation harness (start/result side) and the cone under test (drive/sample side).

---
 rtl/cone_test_pkg.sv | 29 ++
 rtl/cone_vector_sequencer_if.sv | 33 +++
 rtl/cone_settle_timer.sv | 32 +++
 rtl/cone_vector_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cone_test_pkg.sv
// Shared types and helpers for the exhaustive cone-vector sequencer and its
// companion netlist-validation harnesses.
package cone_test_pkg;

    // Sequencer phases: idle, hold a vector, sample the cone, report completion.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

    // Widest cone any harness in this family is expected to sweep.
    localparam int MAX_N_IN = 16;

    // Size of the exhaustive input space for a cone with n_in inputs.
    function automatic int unsigned vec_count(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    // Sweep verdict, sized for the widest supported cone so that harnesses
    // with different N_IN can share one record layout.
    typedef struct packed {
        logic                pass;
        logic [MAX_N_IN:0]   fail_count;
        logic [MAX_N_IN-1:0] first_fail_vec;
    } cone_result_t;

endpackage

// File: rtl/cone_vector_sequencer_if.sv
// Bundle between the validation harness / cone under test (master side) and
// the vector sequencer (slave side). The master side owns both the start
// controls and the cone output, because the harness is what wraps the cone.
interface cone_vector_sequencer_if
    import cone_test_pkg::*;
#(
    parameter int N_IN = 6
);
    localparam int NV = vec_count(N_IN);

    logic              start;
    logic              abort;
    logic [NV-1:0]     expected_tt;
    logic [N_IN-1:0]   cone_in;
    logic              cone_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     fail_count;
    logic [N_IN-1:0]   first_fail_vec;
    logic [NV-1:0]     captured_tt;

    modport master (
        output start, abort, expected_tt, cone_out,
        input  cone_in, busy, done, pass, fail_count, first_fail_vec, captured_tt
    );

    modport slave (
        input  start, abort, expected_tt, cone_out,
        output cone_in, busy, done, pass, fail_count, first_fail_vec, captured_tt
    );

endinterface

// File: rtl/cone_settle_timer.sv
// Load/count/expire counter that measures how long a stimulus has been held.
// Loading clears the count; while enabled it counts up and flags expiry on
// the SETTLE_CYCLES-th enabled cycle, so the caller can leave on that edge.
module cone_settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] r_count;

    // Hold counter: cleared on load, counts while enabled, saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {CW{1'b0}};
        end else if (i_load) begin
            r_count <= {CW{1'b0}};
        end else if (i_en && (r_count != CW'(SETTLE_CYCLES))) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expire = i_en && (r_count == CW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/cone_vector_sequencer.sv
// Exhaustive-vector sequencer for a small combinational cone: walks every
// input vector in ascending order, holds it for SETTLE_CYCLES, samples the
// cone output, and scores it against a truth table latched at start.
module cone_vector_sequencer
    import cone_test_pkg::*;
#(
    parameter int N_IN          = 6,
    parameter int SETTLE_CYCLES = 1
) (
    input logic                    clk,
    input logic                    rst,
    cone_vector_sequencer_if.slave bus
);
    localparam int NV = vec_count(N_IN);

    seq_state_e        r_state;
    logic [N_IN-1:0]   r_vec;
    logic [N_IN-1:0]   r_cone_in;
    logic [N_IN-1:0]   r_first;
    logic [N_IN:0]     r_fail;
    logic [NV-1:0]     r_exp_tt;
    logic [NV-1:0]     r_cap_tt;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;

    logic              w_expire;
    logic              w_tmr_load;
    logic              w_tmr_en;
    logic              w_mismatch;
    logic              w_last;
    logic              w_pass_next;

    // The timer runs only while a vector is being held and is cleared in
    // every other state, so each DRIVE visit starts from a zero count.
    assign w_tmr_en   = (r_state == ST_DRIVE);
    assign w_tmr_load = (r_state != ST_DRIVE);

    cone_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_tmr_load),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    assign w_mismatch  = (bus.cone_out != r_exp_tt[r_vec]);
    assign w_last      = (r_vec == N_IN'(NV - 1));
    // Verdict must include the sample taken on the same edge that enters DONE.
    assign w_pass_next = (r_fail == {(N_IN + 1){1'b0}}) && !w_mismatch;

    // Sweep FSM with registered outputs, compare logic and capture register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_vec     <= {N_IN{1'b0}};
            r_cone_in <= {N_IN{1'b0}};
            r_first   <= {N_IN{1'b0}};
            r_fail    <= {(N_IN + 1){1'b0}};
            r_exp_tt  <= {NV{1'b0}};
            r_cap_tt  <= {NV{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_exp_tt  <= bus.expected_tt;
                        r_fail    <= {(N_IN + 1){1'b0}};
                        r_first   <= {N_IN{1'b0}};
                        r_cap_tt  <= {NV{1'b0}};
                        r_pass    <= 1'b0;
                        r_vec     <= {N_IN{1'b0}};
                        r_cone_in <= {N_IN{1'b0}};
                        r_busy    <= 1'b1;
                        r_state   <= ST_DRIVE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (bus.abort) begin
                        r_cone_in <= {N_IN{1'b0}};
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_expire) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_state <= ST_DRIVE;
                    end
                end
                ST_SAMPLE: begin
                    // An abort on the sampling edge discards that sample.
                    if (bus.abort) begin
                        r_cone_in <= {N_IN{1'b0}};
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cap_tt[r_vec] <= bus.cone_out;
                        if (w_mismatch) begin
                            r_fail <= r_fail + (N_IN + 1)'(1);
                            if (r_fail == {(N_IN + 1){1'b0}}) begin
                                r_first <= r_vec;
                            end else begin
                                r_first <= r_first;
                            end
                        end else begin
                            r_fail <= r_fail;
                        end
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= w_pass_next;
                            r_state <= ST_DONE;
                        end else begin
                            r_vec     <= r_vec + N_IN'(1);
                            r_cone_in <= r_vec + N_IN'(1);
                            r_state   <= ST_DRIVE;
                        end
                    end
                end
                ST_DONE: begin
                    // Any start seen here is dropped; it must be re-raised in IDLE.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_cone_in <= {N_IN{1'b0}};
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cone_in        = r_cone_in;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.fail_count     = r_fail;
    assign bus.first_fail_vec = r_first;
    assign bus.captured_tt    = r_cap_tt;

endmodule
